mem_word_sequencer: RTL

Sequences whole-word memory transactions onto the nibble-level QSPI flash/PSRAM controller, which sits directly downstream. After reset it first puts PSRAM into quad mode. It then serves one read or write request at a time, using a valid/ready handshake toward the GPU fetch logic. For each request it pulses the controller's start strobe, streams or collects `WORD_NIBBLES` nibbles in big-endian order, terminates with `stop_txn`, and returns a single-cycle response.

---
 rtl/mem_word_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_sequencer
// Purpose  : Sequences whole-word read/write transactions onto a nibble-level
//            QSPI flash/PSRAM controller. After reset it puts PSRAM into
//            quad mode. It then serves one request at a time: start strobe,
//            WORD_NIBBLES nibbles big-endian, stop strobe, one-cycle response.
// Option   : `define MEM_SEQ_TIMEOUT_EN adds an 8-bit watchdog on INIT_WAIT
//            and XFER. A timed-out transfer is answered with rsp_err.
// Ports    : clk/rst            - clock, synchronous active-high reset
//            req_*              - valid/ready request channel (GPU side)
//            rsp_*              - one-cycle response (valid, read data, error)
//            init_done          - PSRAM quad mode has been entered
//            ctl_*              - command/data interface to the controller
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_sequencer #(
   parameter int ADDR_BITS    = 24,
   parameter int WORD_NIBBLES = 4,
   parameter int TIMEOUT_CYC  = 63
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic                      req_rom,
   input  logic [ADDR_BITS-1:0]      req_addr,
   input  logic [4*WORD_NIBBLES-1:0] req_wdata,
   output logic                      rsp_valid,
   output logic [4*WORD_NIBBLES-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      init_done,
   output logic                      ctl_select_rom,
   output logic                      ctl_enter_quadmode,
   output logic                      ctl_start_read,
   output logic                      ctl_start_write,
   output logic                      ctl_stop_txn,
   output logic [ADDR_BITS-1:0]      ctl_addr,
   output logic [3:0]                ctl_wdata,
   input  logic [3:0]                ctl_rdata,
   input  logic                      ctl_data_ready,
   input  logic                      ctl_data_req,
   input  logic                      ctl_at_quadmode
);

   localparam int         WORD_BITS = 4 * WORD_NIBBLES;
   localparam logic [3:0] LAST_NIB  = 4'(WORD_NIBBLES - 1);
   localparam logic [7:0] WD_LAST   = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      INIT_QM   = 3'd0,
      INIT_WAIT = 3'd1,
      INIT_STOP = 3'd2,
      IDLE      = 3'd3,
      START     = 3'd4,
      XFER      = 3'd5,
      STOP      = 3'd6,
      RESP      = 3'd7
   } state_t;

   state_t                 state;
   logic [3:0]             cnt;
   logic [WORD_BITS-1:0]   word;        // write word (shifted out MSB first) or read accumulator
   logic [WORD_BITS-1:0]   rdata_reg;
   logic [ADDR_BITS-1:0]   addr_reg;
   logic                   rom_reg;
   logic                   is_write;
   logic                   fail;        // transfer ended by the watchdog
   logic                   init_done_reg;

   // Strobe registers: each is loaded on the edge that enters the state it
   // belongs to, so the strobe is high for exactly that state's cycle.
   logic                   enter_reg;
   logic                   start_rd_reg;
   logic                   start_wr_reg;
   logic                   stop_reg;
   logic                   ready_reg;
   logic                   rsp_valid_reg;
   logic                   rsp_err_reg;

   logic                   handshake;
   logic                   last_nib;

   assign handshake = (state == XFER) && (is_write ? ctl_data_req : ctl_data_ready);
   assign last_nib  = (cnt == LAST_NIB);

`ifdef MEM_SEQ_TIMEOUT_EN
   logic [7:0]             wd;
   logic                   retry;
`else
   logic                   unused_timeout;
   assign unused_timeout = ^WD_LAST;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INIT_QM;
         cnt           <= 4'd0;
         word          <= '0;
         rdata_reg     <= '0;
         addr_reg      <= '0;
         rom_reg       <= 1'b0;
         is_write      <= 1'b0;
         fail          <= 1'b0;
         init_done_reg <= 1'b0;
         // Masked at the output while rst is high; becomes visible in the
         // first cycle after release, which is the INIT_QM cycle.
         enter_reg     <= 1'b1;
         start_rd_reg  <= 1'b0;
         start_wr_reg  <= 1'b0;
         stop_reg      <= 1'b0;
         ready_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
         wd            <= 8'd0;
         retry         <= 1'b0;
`endif
      end else begin
         enter_reg     <= 1'b0;
         start_rd_reg  <= 1'b0;
         start_wr_reg  <= 1'b0;
         stop_reg      <= 1'b0;
         ready_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;

         case (state)
            INIT_QM: begin
               state <= INIT_WAIT;
`ifdef MEM_SEQ_TIMEOUT_EN
               wd    <= 8'd0;
`endif
            end

            INIT_WAIT: begin
`ifdef MEM_SEQ_TIMEOUT_EN
               wd <= wd + 8'd1;
               if (wd == WD_LAST) begin
                  state    <= INIT_STOP;
                  stop_reg <= 1'b1;
                  retry    <= 1'b1;
               end
`endif
               // A real completion takes priority over a coincident timeout.
               if (ctl_at_quadmode) begin
                  state    <= INIT_STOP;
                  stop_reg <= 1'b1;
`ifdef MEM_SEQ_TIMEOUT_EN
                  retry    <= 1'b0;
`endif
               end
            end

            INIT_STOP: begin
               state         <= IDLE;
               ready_reg     <= 1'b1;
               init_done_reg <= 1'b1;
`ifdef MEM_SEQ_TIMEOUT_EN
               if (retry) begin
                  state         <= INIT_QM;
                  enter_reg     <= 1'b1;
                  ready_reg     <= 1'b0;
                  init_done_reg <= 1'b0;
                  retry         <= 1'b0;
               end
`endif
            end

            IDLE: begin
               ready_reg <= 1'b1;
               if (req_valid && ready_reg) begin
                  ready_reg <= 1'b0;
                  cnt       <= 4'd0;
                  is_write  <= req_write;
                  word      <= req_wdata;
                  fail      <= 1'b0;
                  if (req_write && req_rom) begin
                     // Flash is read-only: answer at once, never touch the controller.
                     state         <= RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                  end else begin
                     state        <= START;
                     addr_reg     <= req_addr;
                     rom_reg      <= req_rom;
                     start_rd_reg <= ~req_write;
                     start_wr_reg <= req_write;
                  end
               end
            end

            START: begin
               state <= XFER;
`ifdef MEM_SEQ_TIMEOUT_EN
               wd    <= 8'd0;
`endif
            end

            XFER: begin
               if (handshake) begin
                  // One shift serves both directions: reads pull the new nibble
                  // in at the LSB end, writes expose the next nibble at the MSB.
                  word <= (word << 4) | WORD_BITS'(ctl_rdata);
                  cnt  <= cnt + 4'd1;
                  if (last_nib) begin
                     state    <= STOP;
                     stop_reg <= 1'b1;
                  end
               end
`ifdef MEM_SEQ_TIMEOUT_EN
               if (handshake) begin
                  wd <= 8'd0;
               end else if (wd == WD_LAST) begin
                  state    <= STOP;
                  stop_reg <= 1'b1;
                  fail     <= 1'b1;
               end else begin
                  wd <= wd + 8'd1;
               end
`endif
            end

            STOP: begin
               state         <= RESP;
               rsp_valid_reg <= 1'b1;
               rsp_err_reg   <= fail;
               if (!is_write && !fail) begin
                  rdata_reg <= word;
               end
            end

            RESP: begin
               state     <= IDLE;
               ready_reg <= 1'b1;
            end

            default: begin
               state <= INIT_QM;
            end
         endcase
      end
   end

   // While rst is high every output is forced low, except the stop command,
   // which is forced high so the controller idles even without its own reset.
   assign req_ready          = ready_reg     & ~rst;
   assign rsp_valid          = rsp_valid_reg & ~rst;
   assign rsp_err            = rsp_err_reg   & ~rst;
   assign rsp_rdata          = rst ? '0 : rdata_reg;
   assign init_done          = init_done_reg & ~rst;
   assign ctl_select_rom     = rom_reg       & ~rst;
   assign ctl_addr           = rst ? '0 : addr_reg;
   assign ctl_enter_quadmode = enter_reg     & ~rst;
   assign ctl_start_read     = start_rd_reg  & ~rst;
   assign ctl_start_write    = start_wr_reg  & ~rst;
   assign ctl_stop_txn       = stop_reg      |  rst;
   assign ctl_wdata          = (state == XFER && is_write && !rst) ? word[WORD_BITS-1 -: 4] : 4'd0;

endmodule
`default_nettype wire
